pip_reg_skid: RTL and testbench
===============================

PIP_REG_SKID -- requirements
Module: pip_reg_skid

Interface
REQ-001 SHALL have parameter PAYLOAD_WIDTH, default 104, bit width of the bundled stage payload (MEM/WB default: RegWrite 1 + ResultSrc 2 + ALUResult 32 + ReadData 32 + Rd 5 + pcPlus4 32).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of each performance counter.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port valid_i, input, 1, the upstream stage offers payload_i.
REQ-007 SHALL have port ready_o, output, 1, the block accepts payload_i this cycle.
REQ-008 SHALL have port payload_i, input, PAYLOAD_WIDTH, the upstream stage payload.
REQ-009 SHALL have port flush_i, input, 1, discard all held and incoming entries (branch/jump flush).
REQ-010 SHALL have port valid_o, output, 1, payload_o is valid.
REQ-011 SHALL have port ready_i, input, 1, the downstream stage accepts payload_o.
REQ-012 SHALL have port payload_o, output, PAYLOAD_WIDTH, the head entry.
REQ-013 SHALL have port occupancy_o, output, 2, number of held entries (0..2).
REQ-014 SHALL have port stall_cnt_o, output, CNT_WIDTH, cycles with valid_o=1 and ready_i=0.
REQ-015 SHALL have port bubble_cnt_o, output, CNT_WIDTH, cycles with valid_o=0 and ready_i=1.

Function
REQ-016 SHALL define in_fire = valid_i & ready_o and out_fire = valid_o & ready_i.
REQ-017 SHALL implement FSM states EMPTY (0 entries), BUSY (main register only) and FULL (main + skid registers).
REQ-018 SHALL drive ready_o = (state != FULL), valid_o = (state != EMPTY), and payload_o = main register, with no combinational path from ready_i or valid_i to any output.
REQ-019 SHALL, in EMPTY on in_fire, load main from payload_i and go to BUSY; otherwise stay in EMPTY.
REQ-020 SHALL, in BUSY:
- in_fire & out_fire: load main from payload_i, stay in BUSY.
- in_fire only: load skid from payload_i, go to FULL.
- out_fire only: go to EMPTY.
- neither: hold.
REQ-021 SHALL, in FULL on out_fire, load main from skid and go to BUSY; otherwise hold both registers unchanged.
REQ-022 SHALL give one-cycle latency: payload accepted at edge N appears on payload_o after edge N when the block was EMPTY.
REQ-023 SHALL preserve order; no entry is dropped or duplicated except by flush_i.
REQ-024 SHALL, on flush_i=1 at an edge, go to EMPTY regardless of state, in_fire or out_fire; a payload offered that cycle is discarded; payload registers keep their values; counters are unaffected.
REQ-025 SHALL set occupancy_o to 0, 1 or 2 for EMPTY, BUSY or FULL respectively.
REQ-026 SHALL increment each counter by 1 on its qualifying cycle (including flush cycles), saturating at all-ones without wrapping.

Reset
REQ-027 SHALL, on rst_i=1 at an edge: state EMPTY, main and skid all zeros, both counters zero; therefore valid_o=0, ready_o=1, payload_o=0, occupancy_o=0.
REQ-028 SHALL give rst_i priority over flush_i and all handshakes; reset mid-transfer discards all held entries.
REQ-029 SHALL NOT count a reset cycle toward either counter.

Structure
REQ-030 SHALL take the FSM state enum (EMPTY/BUSY/FULL) and the default width constants (DATA_WIDTH 32, PC_WIDTH 32, REGISTER_ADDRESS_WIDTH 5) from the shared package pip_pkg.
REQ-031 SHALL instantiate sub-module sat_counter (parameter WIDTH; ports clk_i, rst_i, inc_i, count_o) once per performance counter.

Verification
REQ-032 SHALL cover the single transfer case: reset, then valid_i=1 with payload 0x...ABCD and ready_i=1 for one cycle -> valid_o=1 with payload_o=0x...ABCD the next cycle, then EMPTY.
REQ-033 SHALL cover backpressure: ready_i=0 while payloads A and B are offered -> occupancy 2, ready_o=0, C held upstream; ready_i=1 -> A, B, C are output in order with no loss.
REQ-034 SHALL cover streaming: ready_i=1 and valid_i=1 for 10 cycles with payloads 1..10 -> outputs 1..10 on consecutive cycles, occupancy stays 1, stall_cnt unchanged.
REQ-035 SHALL cover flush when FULL: flush_i=1 with valid_i=1 (payload X) -> next cycle valid_o=0, occupancy 0, ready_o=1, and X is never output.
REQ-036 SHALL cover counter saturation: CNT_WIDTH=4, ready_i=0 with valid_o=1 for 20 cycles -> stall_cnt_o=15 and holds at 15.
REQ-037 SHALL cover reset in FULL while flush_i=1 -> all outputs at reset values on the next cycle and both counters 0.

Source files
------------

// File: rtl/pip_pkg.sv
// pip_pkg: shared pipeline widths and skid-register FSM state encoding
package pip_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int PC_WIDTH = 32;
  localparam int REGISTER_ADDRESS_WIDTH = 5;
  localparam int MEMWB_WIDTH = 1 + 2 + DATA_WIDTH + DATA_WIDTH + REGISTER_ADDRESS_WIDTH + PC_WIDTH;
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter (clk_i, rst_i sync active-high, inc_i, count_o)
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = (inc_i && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else count_q <= count_d;
  end
  assign count_o = count_q;
endmodule

// File: rtl/pip_reg_skid.sv
// pip_reg_skid: two-entry skid pipeline register with flush and stall/bubble counters (valid/ready/payload in and out, flush_i, occupancy_o, stall_cnt_o, bubble_cnt_o)
module pip_reg_skid
  import pip_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = MEMWB_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [PAYLOAD_WIDTH-1:0] payload_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [PAYLOAD_WIDTH-1:0] payload_o,
  output logic [1:0]               occupancy_o,
  output logic [CNT_WIDTH-1:0]     stall_cnt_o,
  output logic [CNT_WIDTH-1:0]     bubble_cnt_o
);
  state_e state_q, state_d;
  logic [PAYLOAD_WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic in_fire, out_fire;
  assign ready_o = state_q != FULL;
  assign valid_o = state_q != EMPTY;
  assign payload_o = main_q;
  assign occupancy_o = state_q;
  assign in_fire = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush_i) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          main_d = payload_i;
          state_d = BUSY;
        end
        BUSY: if (in_fire && out_fire) main_d = payload_i;
        else if (in_fire) begin
          skid_d = payload_i;
          state_d = FULL;
        end else if (out_fire) state_d = EMPTY;
        FULL: if (out_fire) begin
          main_d = skid_q;
          state_d = BUSY;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(valid_o & ~ready_i), .count_o(stall_cnt_o)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_bubble (
    .clk_i(clk_i), .rst_i(rst_i), .inc_i(~valid_o & ready_i), .count_o(bubble_cnt_o)
  );
endmodule

// File: tb/tb_pip_reg_skid.sv
// tb_pip_reg_skid: directed self-checking bench for pip_reg_skid
module tb_pip_reg_skid;
  localparam int PW = 104;
  localparam int CW = 4;
  logic clk = 0, rst = 1, valid_i = 0, ready_i = 0, flush_i = 0;
  logic [PW-1:0] payload_i = '0;
  logic ready_o, valid_o;
  logic [PW-1:0] payload_o;
  logic [1:0] occ;
  logic [CW-1:0] stall_cnt, bubble_cnt;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pip_reg_skid #(.PAYLOAD_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .payload_i(payload_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .payload_o(payload_o), .occupancy_o(occ), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    check("rst_valid", valid_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_payload", payload_o, 0);
    check("rst_occ", occ, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_bubble", bubble_cnt, 0);

    valid_i = 1; ready_i = 1; payload_i = 104'hABCD;
    tick();
    check("single_valid", valid_o, 1);
    check("single_payload", payload_o, 104'hABCD);
    check("single_occ", occ, 1);
    valid_i = 0;
    tick();
    check("single_empty", valid_o, 0);
    check("single_occ0", occ, 0);
    check("single_bubble", bubble_cnt, 1);

    ready_i = 0; valid_i = 1; payload_i = 104'hA;
    tick();
    check("bp_occ1", occ, 1);
    payload_i = 104'hB;
    tick();
    check("bp_occ2", occ, 2);
    check("bp_ready0", ready_o, 0);
    check("bp_headA", payload_o, 104'hA);
    payload_i = 104'hC;
    tick();
    check("bp_hold_occ", occ, 2);
    check("bp_hold_A", payload_o, 104'hA);
    check("bp_stall", stall_cnt, 2);
    ready_i = 1;
    tick();
    check("bp_outB", payload_o, 104'hB);
    check("bp_occ_b", occ, 1);
    tick();
    check("bp_outC", payload_o, 104'hC);
    check("bp_occ_c", occ, 1);
    valid_i = 0;
    tick();
    check("bp_drain", occ, 0);

    valid_i = 1;
    for (int i = 1; i <= 10; i++) begin
      payload_i = PW'(i);
      tick();
      check("stream_payload", payload_o, 128'(i));
      check("stream_occ", occ, 1);
    end
    valid_i = 0;
    tick();
    check("stream_stall", stall_cnt, 2);
    check("stream_bubble", bubble_cnt, 2);

    ready_i = 0; valid_i = 1; payload_i = 104'h11;
    tick();
    payload_i = 104'h22;
    tick();
    check("fl_full", occ, 2);
    flush_i = 1; payload_i = 104'hDEAD;
    tick();
    check("fl_valid", valid_o, 0);
    check("fl_occ", occ, 0);
    check("fl_ready", ready_o, 1);
    check("fl_stall", stall_cnt, 4);
    flush_i = 0; valid_i = 0; ready_i = 1;
    tick();
    check("fl_no_x1", valid_o, 0);
    tick();
    check("fl_no_x2", valid_o, 0);
    check("fl_bubble", bubble_cnt, 4);

    ready_i = 0; valid_i = 1; payload_i = 104'h33;
    tick();
    valid_i = 0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall", stall_cnt, 15);
    check("sat_head", payload_o, 104'h33);
    tick();
    tick();
    check("sat_hold", stall_cnt, 15);

    valid_i = 1; payload_i = 104'h44;
    tick();
    check("rf_full", occ, 2);
    rst = 1; flush_i = 1; ready_i = 1;
    tick();
    rst = 0; flush_i = 0; valid_i = 0; ready_i = 0;
    check("rf_valid", valid_o, 0);
    check("rf_ready", ready_o, 1);
    check("rf_payload", payload_o, 0);
    check("rf_occ", occ, 0);
    check("rf_stall", stall_cnt, 0);
    check("rf_bubble", bubble_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
